// File: rtl/ram_demo_pkg.sv
// ---------------------------------------------------------------------------
// ram_demo_pkg : shared state encoding and data pattern for the RAM demo
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_demo_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // Writer and checker both call this, so the pattern has a single definition.
  function automatic logic [31:0] exp_data(input logic [31:0] addr, input logic [31:0] seed);
    return addr + seed;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_rd_pipe.sv
// ---------------------------------------------------------------------------
// ram_rd_pipe : RD_LAT-deep {valid, addr} delay line matching RAM read latency
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_rd_pipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_addr
);

  logic [RD_LAT-1:0] r_vld;
  logic [ADDR_W-1:0] r_addr [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_addr[i] <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_addr[0] <= i_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  assign o_vld  = r_vld[RD_LAT-1];
  assign o_addr = r_addr[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/ram_rd_check.sv
// ---------------------------------------------------------------------------
// ram_rd_check : sequential RAM read-back verifier with error count/address
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_rd_check
  import ram_demo_pkg::*;
#(
  parameter int                ADDR_W = 5,
  parameter int                DEPTH  = 32,
  parameter int                DATA_W = 8,
  parameter int                RD_LAT = 1,
  parameter logic [DATA_W-1:0] SEED   = '0,
  parameter int                CNT_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_first_err;
  logic              r_pass;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_pv;
  logic [ADDR_W-1:0] w_paddr;
  logic [DATA_W-1:0] w_exp;
  logic              w_mismatch;
  logic              w_drain_done;

  assign w_issue      = (r_state == S_READ);
  assign w_last_issue = w_issue && (r_addr == c_last_addr);

  ram_rd_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk    (sys_clk),
    .rst_n  (sys_rst),
    .i_vld  (w_issue),
    .i_addr (r_addr),
    .o_vld  (w_pv),
    .o_addr (w_paddr)
  );

  assign w_exp        = DATA_W'(exp_data(32'(w_paddr), 32'(SEED)));
  assign w_mismatch   = w_pv && (ram_dout != w_exp);
  // The last address leaving the pipe marks the final comparison of the pass.
  assign w_drain_done = w_pv && (w_paddr == c_last_addr);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)        w_next = S_READ;
      S_READ:  if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_done) w_next = S_FIN;
      S_FIN:                     w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ram_en   = w_issue;
    ram_we   = 1'b0;
    ram_addr = w_issue ? r_addr : '0;
    busy     = (r_state == S_READ) || (r_state == S_DRAIN);
    done     = (r_state == S_FIN);
    pass     = (r_state == S_FIN) ? (r_err_cnt == '0) : r_pass;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_addr      <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_addr      <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_pass      <= 1'b0;
    end else begin
      if (w_issue && !w_last_issue) r_addr <= r_addr + 1'b1;
      if (w_mismatch) begin
        if (r_err_cnt != c_cnt_max) r_err_cnt <= r_err_cnt + 1'b1;
        if (r_err_cnt == '0)        r_first_err <= w_paddr;
      end
      if (r_state == S_FIN) r_pass <= (r_err_cnt == '0);
    end
  end

  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err;

endmodule

`default_nettype wire

// File: doc/ram_rd_check.md
Name: ram_rd_check

Overview:
Read-back verifier for the single-port RAM demo. After the write side fills the RAM with a known pattern, this block takes over the RAM port and reads every address in sequence. It compares each returned word against the expected pattern and reports pass/fail, an error count and the first failing address. It sits in top beside the RAM writer and shares the RAM IP port with it; top muxes the port on the writer's done/start.

Parameters:
ADDR_W, 5, RAM address width
DEPTH, 32, number of words checked (1..2**ADDR_W); addresses 0..DEPTH-1
DATA_W, 8, RAM data width
RD_LAT, 1, RAM IP read latency in cycles (1 = no output register, 2 = output register); legal 1..4
SEED, 8'h00, pattern offset; expected word = (addr + SEED) truncated to DATA_W
CNT_W, 8, error counter width

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin a check pass
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable; always 0 from this block
ram_addr  out  ADDR_W  RAM address
ram_dout  in  DATA_W  RAM read data, valid RD_LAT cycles after the address
busy  out  1  high from the cycle after start until done
done  out  1  single-cycle pulse when the pass completes
pass  out  1  sticky: 1 if the last pass saw no mismatch
err_cnt  out  CNT_W  mismatches in the last pass, saturating
first_err_addr  out  ADDR_W  address of the first mismatch in the last pass

Behaviour:
- Reset (sys_rst low, asynchronous): state IDLE; ram_en=0, ram_we=0, ram_addr=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0; read pipeline valid bits cleared.
- States: IDLE, READ, DRAIN, FIN.
- IDLE: when start=1, go to READ, set busy=1, clear err_cnt, first_err_addr and pass, and set the address counter to 0.
- READ: ram_en=1 and ram_addr=counter every cycle; counter increments. After address DEPTH-1 is issued, go to DRAIN; ram_en drops the following cycle.
- DRAIN: wait until the last issued address has left the read pipeline (RD_LAT cycles), then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, and pass=(err_cnt==0). Return to IDLE.
- Read pipeline: a valid bit plus the address is delayed RD_LAT cycles. When the delayed valid is 1, compare ram_dout against (delayed_addr+SEED)[DATA_W-1:0].
- On mismatch: err_cnt increments and saturates at 2**CNT_W-1. first_err_addr is captured only on the first mismatch of the pass.
- Total latency: start at cycle 0, first ram_en at cycle 1, done at cycle DEPTH+RD_LAT+1.
- start while busy: ignored; the pass is not restarted.
- start in the same cycle as FIN: ignored; a new start is needed once back in IDLE.
- Reset mid-pass: everything returns to reset values immediately; in-flight reads are discarded.
- DEPTH=1: a single read, done at cycle RD_LAT+2.
- Address counter never wraps: READ exits at DEPTH-1, even when DEPTH=2**ADDR_W.
- ram_we is held 0 in every state; the block never writes.

Decomposition:
- Shared package ram_demo_pkg holds:
  - state encoding localparams (S_IDLE=2'd0, S_READ=2'd1, S_DRAIN=2'd2, S_FIN=2'd3);
  - the pattern function exp_data(addr, seed), also used by the RAM writer so both sides agree.
- One natural sub-module: ram_rd_pipe, a RD_LAT-deep shift register carrying {valid, addr}, with asynchronous active-low clear.

Test Plan:
- RAM model (RD_LAT=1) preloaded with addr+0 for 32 words; pulse start at 210 ns -> done 34 cycles after start, pass=1, err_cnt=0, ram_we never 1.
- Same, but word 5 = 8'hFF and word 20 = 8'h00 -> pass=0, err_cnt=2, first_err_addr=5.
- RD_LAT=2 with the model's output register, clean pattern -> done at cycle DEPTH+3, pass=1; corrupt word 31 -> err_cnt=1, first_err_addr=31 (last word checked after drain).
- CNT_W=2, all 32 words corrupt -> err_cnt saturates at 3, first_err_addr=0, pass=0.
- Pulse start again at cycle 10 of a pass -> no restart, exactly one done pulse at the expected cycle.
- Assert sys_rst low at cycle 15 of a pass, release, pulse start -> outputs at reset values during reset; a fresh full pass then completes with correct results.
